call_return_ctrl: RTL

- Control stage directly upstream of the 16x32 return-address stack; sits between instruction decode and the stack.
- Converts decoded CALL/RET requests into single-cycle push/pop strobes and drives the PC redirect.
- Keeps a mirror depth counter, because the stack exposes no full/empty flags.
- Detects overflow, underflow and illegal simultaneous requests, and holds the core in a sticky fault until cleared.

---
 rtl/call_return_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/call_return_ctrl.sv
// rtl/call_return_ctrl.sv - CALL/RET to return-stack strobe control with PC redirect and sticky fault
module call_return_ctrl #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call,
  input  logic          ret,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] call_target,
  input  logic          fault_clr,
  input  logic [DW-1:0] stk_dataout,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_datain,
  output logic          pc_load,
  output logic [DW-1:0] pc_next,
  output logic          stall,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [CW-1:0] depth
);

  typedef enum logic [1:0] {IDLE, CALL_RDR, RET_RDR, FAULT} state_t;

  localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);

  state_t        state, state_nxt;
  logic [CW-1:0] depth_nxt;
  logic          fault_nxt;
  logic [1:0]    code_nxt;
  logic [DW-1:0] pc_next_nxt;
  logic          do_push, do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      depth      <= '0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      pc_next    <= '0;
    end else begin
      state      <= state_nxt;
      depth      <= depth_nxt;
      fault      <= fault_nxt;
      fault_code <= code_nxt;
      pc_next    <= pc_next_nxt;
    end
  end

  // Simultaneous call+ret is classified before any depth check.
  always_comb begin
    state_nxt   = state;
    depth_nxt   = depth;
    fault_nxt   = fault;
    code_nxt    = fault_code;
    pc_next_nxt = pc_next;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (call && ret) begin
          state_nxt = FAULT;
          fault_nxt = 1'b1;
          code_nxt  = 2'd3;
        end else if (call) begin
          if (depth == DEPTH_MAX) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
            code_nxt  = 2'd1;
          end else begin
            do_push     = 1'b1;
            depth_nxt   = depth + CW'(1);
            pc_next_nxt = call_target;
            state_nxt   = CALL_RDR;
          end
        end else if (ret) begin
          if (depth == '0) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
            code_nxt  = 2'd2;
          end else begin
            do_pop      = 1'b1;
            depth_nxt   = depth - CW'(1);
            pc_next_nxt = stk_dataout;
            state_nxt   = RET_RDR;
          end
        end
      end
      CALL_RDR, RET_RDR: state_nxt = IDLE;
      FAULT: begin
        if (fault_clr) begin
          state_nxt = IDLE;
          fault_nxt = 1'b0;
          code_nxt  = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are masked while reset is held so the stack sees nothing during reset.
  assign stk_push   = do_push & rst_n;
  assign stk_pop    = do_pop & rst_n;
  assign stk_datain = stk_push ? pc + DW'(1) : '0;
  assign pc_load    = (state == CALL_RDR) || (state == RET_RDR);
  assign stall      = (state != IDLE);

endmodule
